// File: rtl/imem_pkg.sv
// Shared FSM type and constants for the instruction-memory fetch server.
package imem_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CHECK,
      S_RUN,
      S_ERROR
   } imem_state_t;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
   localparam int unsigned WORD_BYTES        = 4;

endpackage

// File: rtl/imem_fetch_server.sv
// Fetch-port instruction memory: streams a program image in, then serves komut = mem[pc].
// Build macro IMEM_CHECKSUM_EN: image ends with a wrap-around sum word verified in CHECK.
module imem_fetch_server
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load_start,
   input  logic                   load_valid,
   output logic                   load_ready,
   input  logic [31:0]            load_data,
   input  logic                   load_last,
   input  logic [31:0]            pc,
   output logic [31:0]            komut,
   output logic                   core_reset,
   output logic                   fetch_err,
   output logic                   load_err,
   output logic [$clog2(DEPTH):0] word_count
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned BSH = $clog2(WORD_BYTES);

   imem_state_t   state;
   logic [CW-1:0] count_q;
   logic          load_err_q;
   logic          core_reset_q;
   logic [31:0]   mem [DEPTH];

   logic          accept;
   logic          full;
   logic          chk_word;
   logic          store;
   logic          overflow;

   // load_start wins over a word presented in the same cycle
   assign load_ready = (state == S_LOAD) && !load_start;
   assign accept     = load_ready && load_valid;
   assign full       = (count_q == CW'(DEPTH));

`ifdef IMEM_CHECKSUM_EN
   assign chk_word = accept && load_last;
`else
   assign chk_word = 1'b0;
`endif

   assign store    = accept && !chk_word && !full;
   assign overflow = accept && !chk_word && full;

`ifdef IMEM_CHECKSUM_EN
   logic [31:0] sum_q;
   logic [31:0] chk_q;
   logic        sum_ok;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum_q <= '0;
         chk_q <= '0;
      end else if (load_start) begin
         sum_q <= '0;
      end else begin
         if (store)    sum_q <= sum_q + load_data;
         if (chk_word) chk_q <= load_data;
      end
   end

   assign sum_ok = (sum_q == chk_q);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         count_q      <= '0;
         load_err_q   <= 1'b0;
         core_reset_q <= 1'b0;
      end else begin
         core_reset_q <= (state == S_RUN) && !load_start;
         if (load_start) begin
            state      <= S_LOAD;
            count_q    <= '0;
            load_err_q <= 1'b0;
         end else begin
            case (state)
               S_LOAD: begin
                  if (store) count_q <= count_q + CW'(1);
                  if (overflow) begin
                     load_err_q <= 1'b1;
                     state      <= S_ERROR;
                  end
`ifdef IMEM_CHECKSUM_EN
                  else if (chk_word) state <= S_CHECK;
`else
                  else if (store && load_last) state <= S_RUN;
`endif
               end
`ifdef IMEM_CHECKSUM_EN
               S_CHECK: begin
                  if (sum_ok) begin
                     state <= S_RUN;
                  end else begin
                     load_err_q <= 1'b1;
                     state      <= S_ERROR;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

   // Not reset: image contents survive reset, only the valid count is cleared
   always_ff @(posedge clk) begin
      if (store) mem[count_q[AW-1:0]] <= load_data;
   end

   logic [31:0] offset;
   logic [31:0] idx;
   logic        fault;

   always_comb begin
      offset    = pc - BASE_ADDR;
      idx       = offset >> BSH;
      fault     = (|pc[BSH-1:0]) || (pc < BASE_ADDR) || (idx >= 32'(count_q));
      komut     = NOP_INSTR;
      fetch_err = 1'b0;
      if (state == S_RUN) begin
         if (fault) fetch_err = 1'b1;
         else       komut     = mem[idx[AW-1:0]];
      end
   end

   assign core_reset = core_reset_q;
   assign load_err   = load_err_q;
   assign word_count = count_q;

endmodule

// File: tb/tb_imem_fetch_server.sv
// Randomized self-checking bench for imem_fetch_server against an array-based image model.
module tb_imem_fetch_server;

   localparam int unsigned DEPTH = 64;
   localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IMEM_CHECKSUM_EN
   localparam int CHK_EN = 1;
`else
   localparam int CHK_EN = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_start = 1'b0;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [31:0] load_data = '0;
   logic        load_last = 1'b0;
   logic [31:0] pc = '0;
   logic [31:0] komut;
   logic        core_reset;
   logic        fetch_err;
   logic        load_err;
   logic [6:0]  word_count;

   imem_fetch_server #(
      .DEPTH     (DEPTH),
      .BASE_ADDR (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_last  (load_last),
      .pc         (pc),
      .komut      (komut),
      .core_reset (core_reset),
      .fetch_err  (fetch_err),
      .load_err   (load_err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   // Reference model: the served image is m_img[0 .. m_count-1], visible only while m_run.
   logic [31:0] m_img [DEPTH];
   int          m_count = 0;
   bit          m_run = 0;
   logic [31:0] stim [DEPTH];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_fetch(input logic [31:0] pc_v);
      bit          fault;
      logic [31:0] exp;
      @(negedge clk);
      pc = pc_v;
      #1;
      fault = 0;
      exp   = NOP;
      if (m_run) begin
         fault = (pc_v % 4 != 0) || (pc_v / 4 >= m_count);
         if (!fault) exp = m_img[pc_v / 4];
      end
      check_val("komut", komut, exp);
      check_val("fetch_err", fetch_err, fault);
   endtask

   task automatic random_fetches(input int n);
      logic [31:0] r;
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, (DEPTH + 8) * 4 - 1);
         if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
         check_fetch(r);
      end
   endtask

   task automatic start_load();
      @(negedge clk);
      load_start = 1'b1;
      load_valid = 1'b1;
      load_data  = $urandom;
      load_last  = 1'b1;
      #1 check_val("ready_on_start", load_ready, 0);
      @(negedge clk);
      load_start = 1'b0;
      load_valid = 1'b0;
      load_last  = 1'b0;
      m_count = 0;
      m_run   = 0;
      #1;
      check_val("start_core_reset", core_reset, 0);
      check_val("start_word_count", word_count, 0);
      check_val("start_load_err", load_err, 0);
   endtask

   task automatic send_word(input logic [31:0] d, input bit last);
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) @(negedge clk);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      #1 check_val("ready_in_load", load_ready, 1);
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   // Loads stim[0..n-1]; with the checksum build, bad_sum sends a wrong trailer.
   task automatic load_image(input int n, input bit bad_sum);
      logic [31:0] sum;
      sum = '0;
      start_load();
      for (int i = 0; i < n; i++) begin
         sum = sum + stim[i];
         send_word(stim[i], (i == n - 1) && (CHK_EN == 0));
         if (i < DEPTH) begin
            m_img[i] = stim[i];
            m_count  = i + 1;
         end
      end
      if (CHK_EN != 0) begin
         send_word(bad_sum ? sum + 32'd1 : sum, 1'b1);
         @(negedge clk);
      end
      #1;
      check_val("entry_word_count", word_count, n);
      check_val("entry_core_reset", core_reset, 0);
      if (CHK_EN != 0 && bad_sum) begin
         check_val("sum_load_err", load_err, 1);
         m_run = 0;
      end else begin
         check_val("entry_load_err", load_err, 0);
         @(negedge clk);
         #1 check_val("run_core_reset", core_reset, 1);
         m_run = 1;
      end
   endtask

   initial begin
      // Async reset with no clock edge involved
      #3 reset = 1'b0;
      #1;
      check_val("rst_load_ready", load_ready, 0);
      check_val("rst_core_reset", core_reset, 0);
      check_val("rst_load_err", load_err, 0);
      check_val("rst_word_count", word_count, 0);
      check_val("rst_komut", komut, NOP);
      check_val("rst_fetch_err", fetch_err, 0);
      @(negedge clk);
      reset = 1'b1;

      // Idle: no service, no load acceptance
      load_valid = 1'b1;
      #1 check_val("idle_ready", load_ready, 0);
      load_valid = 1'b0;
      random_fetches(4);

      // Three-word image
      stim[0] = $urandom; stim[1] = $urandom; stim[2] = $urandom;
      load_image(3, 0);
      check_fetch(32'd0);
      check_fetch(32'd4);
      check_fetch(32'd8);
      check_fetch(32'd12);
      check_fetch(32'd6);
      check_fetch(32'hFFFF_FFFC);
      random_fetches(12);

      // Overflow: 65 words, none tagged last
      start_load();
      for (int i = 0; i < DEPTH + 1; i++) begin
         stim[i % DEPTH] = $urandom;
         send_word(stim[i % DEPTH], 1'b0);
      end
      load_valid = 1'b1;
      #1;
      check_val("ovf_load_err", load_err, 1);
      check_val("ovf_word_count", word_count, DEPTH);
      check_val("ovf_core_reset", core_reset, 0);
      check_val("ovf_ready", load_ready, 0);
      load_valid = 1'b0;
      random_fetches(3);

      // Full-depth image, boundary at the last word
      for (int i = 0; i < DEPTH; i++) stim[i] = $urandom;
      load_image(DEPTH, 0);
      check_fetch((DEPTH - 1) * 4);
      check_fetch(DEPTH * 4);
      check_fetch(32'd0);

      // Reload from RUN with a shorter image; old word 2 must no longer be served
      @(negedge clk);
      #1 check_val("pre_reload_core_reset", core_reset, 1);
      stim[0] = $urandom; stim[1] = $urandom;
      load_image(2, 0);
      check_fetch(32'd8);
      check_fetch(32'd4);
      check_val("reload_word_count", word_count, 2);

      // Random images
      for (int it = 0; it < 4; it++) begin
         int n;
         n = $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++) stim[i] = $urandom;
         load_image(n, 0);
         random_fetches(10);
      end

`ifdef IMEM_CHECKSUM_EN
      stim[0] = 32'd1; stim[1] = 32'd2;
      load_image(2, 0);
      check_fetch(32'd4);
      load_image(2, 1);
      check_val("badsum_core_reset", core_reset, 0);
      random_fetches(3);
`endif

      // Async reset in the middle of a load
      start_load();
      for (int i = 0; i < 5; i++) send_word($urandom, 1'b0);
      check_val("midload_count", word_count, 5);
      load_valid = 1'b1;
      #2 reset = 1'b0;
      #1;
      m_count = 0;
      m_run   = 0;
      check_val("mid_rst_ready", load_ready, 0);
      check_val("mid_rst_word_count", word_count, 0);
      check_val("mid_rst_core_reset", core_reset, 0);
      check_val("mid_rst_load_err", load_err, 0);
      check_val("mid_rst_komut", komut, NOP);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      check_val("post_rst_idle_ready", load_ready, 0);
      check_val("post_rst_word_count", word_count, 0);
      load_valid = 1'b0;
      random_fetches(3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
